// File: rtl/mem_arbiter.sv
// Memory-side arbiter for the instruction and data cache request ports.
// Both requestors share one RAM port; the data side wins ties, but a run of
// MAX_D_STREAK data grants while an instruction read waits forces one
// instruction grant. Every access ends with a one-cycle wait pulse, even on
// RAM error or timeout, in which case err is set and the load register gets
// a poison pattern.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_D_STREAK   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction cache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // data cache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0]  RamAccess = 2'd2;
  localparam logic [1:0]  RamError  = 2'd3;
  localparam logic [31:0] Poison    = 32'hBAD1_BAD1;

  typedef enum logic [2:0] {
    StIdle,
    StDServ,
    StIServ,
    StDDone,
    StIDone
  } state_e;

  state_e        state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tmo_cnt;

  logic tmo_hit;
  // Last permitted service cycle before the access is abandoned
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Single FSM: all outputs are registered so waits and strobes are glitch-free
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= StIdle;
      iwait    <= 1'b1;
      dwait    <= 1'b1;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      err      <= 1'b0;
      streak   <= '0;
      tmo_cnt  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if ((dREN || dWEN) && !(iREN && (streak == SW'(MAX_D_STREAK)))) begin
            state    <= StDServ;
            ramaddr  <= daddr;
            ramstore <= dstore;
            // a simultaneous read and write request is treated as a write
            ramWEN   <= dWEN;
            ramREN   <= ~dWEN;
            streak   <= iREN ? streak + SW'(1) : '0;
          end else if (iREN) begin
            state    <= StIServ;
            ramaddr  <= iaddr;
            ramstore <= '0;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
            streak   <= '0;
          end
        end

        StDServ: begin
          if (ramstate == RamAccess) begin
            // ramWEN still holds the latched op for this access
            if (!ramWEN) dload <= ramload;
            state   <= StDDone;
            dwait   <= 1'b0;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            tmo_cnt <= '0;
          end else if ((ramstate == RamError) || tmo_hit) begin
            err     <= 1'b1;
            dload   <= Poison;
            state   <= StDDone;
            dwait   <= 1'b0;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        StIServ: begin
          if (ramstate == RamAccess) begin
            iload   <= ramload;
            state   <= StIDone;
            iwait   <= 1'b0;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            tmo_cnt <= '0;
          end else if ((ramstate == RamError) || tmo_hit) begin
            err     <= 1'b1;
            iload   <= Poison;
            state   <= StIDone;
            iwait   <= 1'b0;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        StDDone: begin
          state <= StIdle;
          dwait <= 1'b1;
        end

        StIDone: begin
          state <= StIdle;
          iwait <= 1'b1;
        end

        default: begin
          state  <= StIdle;
          iwait  <= 1'b1;
          dwait  <= 1'b1;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, data write, priority
// and starvation, RAM error, timeout and reset abort.
module tb_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  logic        ram_auto;
  logic [1:0]  ram_drv;

  int n_pass;
  int n_total;

  // Auto mode: RAM answers ACCESS in the first cycle of any strobe
  assign ramstate = ram_auto ? ((ramREN || ramWEN) ? 2'd2 : 2'd0) : ram_drv;

  mem_arbiter #(
    .TIMEOUT_CYCLES(64),
    .MAX_D_STREAK  (4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .err     (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_total++;
      if (iwait !== 1'b1 || dwait !== 1'b1)
        $display("FAIL reset_waits: cycle %0d got iwait=%b dwait=%b want 1 1", c, iwait, dwait);
      else n_pass++;
      n_total++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0 || err !== 1'b0)
        $display("FAIL reset_strobes: cycle %0d got REN=%b WEN=%b err=%b want 0 0 0",
                 c, ramREN, ramWEN, err);
      else n_pass++;
    end
    n_total++;
    if (iload !== 32'h0 || dload !== 32'h0 || ramaddr !== 32'h0 || ramstore !== 32'h0)
      $display("FAIL reset_regs: got iload=%h dload=%h addr=%h store=%h want all 0",
               iload, dload, ramaddr, ramstore);
    else n_pass++;
  endtask

  task automatic test_single_read();
    ram_drv = 2'd1;
    ramload = 32'h1234_5678;
    iREN    = 1'b1;
    iaddr   = 32'h40;
    tick();
    iREN = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) ram_drv = 2'd2;
      n_total++;
      if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40)
        $display("FAIL read_strobe: cycle %0d got REN=%b WEN=%b addr=%h want 1 0 00000040",
                 c, ramREN, ramWEN, ramaddr);
      else n_pass++;
      n_total++;
      if (iwait !== 1'b1)
        $display("FAIL read_early_wait: cycle %0d got iwait=%b want 1", c, iwait);
      else n_pass++;
      tick();
    end
    ram_drv = 2'd0;
    n_total++;
    if (iwait !== 1'b0 || dwait !== 1'b1 || iload !== 32'h1234_5678)
      $display("FAIL read_done: got iwait=%b dwait=%b iload=%h want 0 1 12345678",
               iwait, dwait, iload);
    else n_pass++;
    n_total++;
    if (ramREN !== 1'b0)
      $display("FAIL read_done_strobe: got ramREN=%b want 0", ramREN);
    else n_pass++;
    tick();
    n_total++;
    if (iwait !== 1'b1 || iload !== 32'h1234_5678)
      $display("FAIL read_hold: got iwait=%b iload=%h want 1 12345678", iwait, iload);
    else n_pass++;
  endtask

  task automatic test_data_write();
    ram_drv = 2'd2;
    dWEN    = 1'b1;
    daddr   = 32'h100;
    dstore  = 32'hDEAD_BEEF;
    ramload = 32'h5555_AAAA;
    tick();
    dWEN = 1'b0;
    n_total++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h100)
      $display("FAIL write_strobe: got WEN=%b REN=%b store=%h addr=%h want 1 0 deadbeef 00000100",
               ramWEN, ramREN, ramstore, ramaddr);
    else n_pass++;
    tick();
    n_total++;
    if (dwait !== 1'b0 || iwait !== 1'b1 || ramWEN !== 1'b0)
      $display("FAIL write_done: got dwait=%b iwait=%b WEN=%b want 0 1 0", dwait, iwait, ramWEN);
    else n_pass++;
    n_total++;
    if (dload !== 32'h0)
      $display("FAIL write_no_load: got dload=%h want 00000000", dload);
    else n_pass++;
    tick();
    n_total++;
    if (dwait !== 1'b1)
      $display("FAIL write_wait_one: got dwait=%b want 1", dwait);
    else n_pass++;
    // read and write together: the write wins
    dREN = 1'b1;
    dWEN = 1'b1;
    tick();
    dREN = 1'b0;
    dWEN = 1'b0;
    n_total++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0)
      $display("FAIL write_wins: got WEN=%b REN=%b want 1 0", ramWEN, ramREN);
    else n_pass++;
    tick();
    tick();
    ram_drv = 2'd0;
  endtask

  task automatic test_priority();
    logic [9:0] order;
    int         cnt;
    int         both;
    order    = '0;
    cnt      = 0;
    both     = 0;
    ram_auto = 1'b1;
    ramload  = 32'h0BAD_F00D;
    iREN     = 1'b1;
    dREN     = 1'b1;
    iaddr    = 32'h80;
    daddr    = 32'h200;
    for (int c = 0; c < 60 && cnt < 10; c++) begin
      tick();
      if (iwait === 1'b0 && dwait === 1'b0) both++;
      if (iwait === 1'b0) begin
        order[cnt] = 1'b1;
        cnt++;
      end else if (dwait === 1'b0) begin
        cnt++;
      end
    end
    iREN = 1'b0;
    dREN = 1'b0;
    n_total++;
    if (cnt != 10)
      $display("FAIL prio_count: got %0d completions want 10", cnt);
    else n_pass++;
    n_total++;
    if (order !== 10'b10_0001_0000)
      $display("FAIL prio_order: got %b want 1000010000 (bit i set = instr completion)", order);
    else n_pass++;
    n_total++;
    if (both != 0)
      $display("FAIL prio_both_low: got %0d cycles with both waits low want 0", both);
    else n_pass++;
    n_total++;
    if (iload !== 32'h0BAD_F00D)
      $display("FAIL prio_iload: got %h want 0badf00d", iload);
    else n_pass++;
    tick();
    tick();
    tick();
    ram_auto = 1'b0;
  endtask

  task automatic test_ram_error();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    ram_drv = 2'd3;
    dREN    = 1'b1;
    daddr   = 32'h300;
    tick();
    dREN = 1'b0;
    tick();
    n_total++;
    if (dwait !== 1'b0 || err !== 1'b1 || dload !== 32'hBAD1_BAD1)
      $display("FAIL ram_error: got dwait=%b err=%b dload=%h want 0 1 bad1bad1", dwait, err, dload);
    else n_pass++;
    ram_drv = 2'd0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_total++;
    if (err !== 1'b0)
      $display("FAIL err_clear: got err=%b want 0", err);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    ram_drv = 2'd1;
    dREN    = 1'b1;
    daddr   = 32'h400;
    tick();
    dREN = 1'b0;
    n = 0;
    while (dwait === 1'b1 && n < 100) begin
      if (n == 63) begin
        n_total++;
        if (err !== 1'b0 || ramREN !== 1'b1)
          $display("FAIL timeout_early: got err=%b REN=%b want 0 1", err, ramREN);
        else n_pass++;
      end
      tick();
      n++;
    end
    n_total++;
    if (n != 64)
      $display("FAIL timeout_len: got %0d service cycles want 64", n);
    else n_pass++;
    n_total++;
    if (dload !== 32'hBAD1_BAD1 || err !== 1'b1)
      $display("FAIL timeout_poison: got dload=%h err=%b want bad1bad1 1", dload, err);
    else n_pass++;
    for (int c = 0; c < 6; c++) tick();
    ram_drv = 2'd0;
    n_total++;
    if (err !== 1'b1 || dwait !== 1'b1)
      $display("FAIL err_sticky: got err=%b dwait=%b want 1 1", err, dwait);
    else n_pass++;
  endtask

  task automatic test_abort();
    int lows;
    lows = 0;
    RST  = 1'b1;
    tick();
    RST = 1'b0;
    ram_drv = 2'd1;
    dREN    = 1'b1;
    daddr   = 32'h500;
    tick();
    dREN = 1'b0;
    n_total++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h500)
      $display("FAIL abort_serv: got REN=%b addr=%h want 1 00000500", ramREN, ramaddr);
    else n_pass++;
    RST = 1'b1;
    tick();
    RST     = 1'b0;
    ram_drv = 2'd2;
    n_total++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0)
      $display("FAIL abort_idle: got REN=%b WEN=%b addr=%h want 0 0 0", ramREN, ramWEN, ramaddr);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      if (dwait !== 1'b1 || iwait !== 1'b1) lows++;
      tick();
    end
    n_total++;
    if (lows != 0)
      $display("FAIL abort_no_pulse: got %0d cycles with a wait low want 0", lows);
    else n_pass++;
    iREN    = 1'b1;
    iaddr   = 32'h44;
    ramload = 32'hCAFE_F00D;
    tick();
    iREN = 1'b0;
    tick();
    n_total++;
    if (iwait !== 1'b0 || iload !== 32'hCAFE_F00D)
      $display("FAIL abort_next_read: got iwait=%b iload=%h want 0 cafef00d", iwait, iload);
    else n_pass++;
    ram_drv = 2'd0;
    tick();
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    RST      = 1'b1;
    iREN     = 1'b0;
    iaddr    = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ram_auto = 1'b0;
    ram_drv  = 2'd0;
    test_reset();
    test_single_read();
    test_data_write();
    test_priority();
    test_ram_error();
    test_timeout();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
